fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pkg.sv | 31 +++
 rtl/fp_mul_pipe_if.sv | 30 +++
 rtl/fp_mul_round.sv | 63 ++++++
 rtl/fp_mul_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared operand classes, flag indices and format helpers for fp_mul_pipe
package fp_mul_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    localparam int FLAG_W         = 5;
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_INEXACT   = 1;
    localparam int FLAG_DENORM    = 0;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Word is right-aligned in 64 bits; callers cast down to 1+EXP_W+MAN_W.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     prod;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       flags;

    modport master (
        output in_valid, a, b, in_tag, out_ready,
        input  in_ready, out_valid, prod, out_tag, flags
    );

    modport slave (
        input  in_valid, a, b, in_tag, out_ready,
        output in_ready, out_valid, prod, out_tag, flags
    );

endinterface

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - combinational normalise, round-to-nearest-even and overflow/underflow pack
module fp_mul_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [2*MAN_W+1:0]       mprod,
    input  logic                     special,
    input  logic [EXP_W+MAN_W:0]     special_word,
    input  logic [4:0]               flags_in,
    output logic [EXP_W+MAN_W:0]     word,
    output logic [4:0]               flags
);
    import fp_mul_pkg::*;

    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] ZERO_S = '0;
    localparam logic signed [XW-1:0] ONE_S  = XW'(1);
    localparam logic signed [XW-1:0] EMAX_S = XW'((1 << EXP_W) - 1);

    logic [PW-1:0]          pn;
    logic signed [XW-1:0]   exp_n;
    logic signed [XW-1:0]   exp_r;
    logic [MAN_W:0]         mant;
    logic [MAN_W+1:0]       mant_r;
    logic [MAN_W-1:0]       frac;
    logic                   g, r, s, up, inexact;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4); align so the hidden bit is the MSB.
        pn      = mprod[PW-1] ? mprod : {mprod[PW-2:0], 1'b0};
        exp_n   = exp_in + (mprod[PW-1] ? ONE_S : ZERO_S);
        mant    = pn[PW-1 -: MAN_W+1];
        g       = pn[MAN_W];
        r       = pn[MAN_W-1];
        s       = |pn[MAN_W-2:0];
        inexact = g | r | s;
        up      = g & (r | s | mant[0]);
        mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
        exp_r   = exp_n + (mant_r[MAN_W+1] ? ONE_S : ZERO_S);
        // On carry-out the mantissa is exactly 10..0, so the shifted fraction is all zero.
        frac    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        word  = {sign, exp_r[EXP_W-1:0], frac};
        flags = flags_in;
        if (special) begin
            word = special_word;
        end else if (exp_r >= EMAX_S) begin
            word                  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[FLAG_OVERFLOW]  = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r <= ZERO_S) begin
            word                  = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            flags[FLAG_INEXACT]   = inexact;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage IEEE-style multiplier with tag sideband; FP_MUL_PIPE_STICKY_FLAGS_EN adds sticky flags
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    fp_mul_pipe_if.slave  bus
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
    ,
    input  logic          flags_clr,
    output logic [4:0]    sticky_flags
`endif
);
    import fp_mul_pkg::*;

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_S = XW'(exp_bias(EXP_W));
    localparam logic [W-1:0]         QNAN_W = W'(canon_qnan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return ZERO;
        if (e != '1) return NORMAL;
        if (m == '0) return INF;
        return m[MAN_W-1] ? QNAN : SNAN;
    endfunction

    logic adv;

    logic                 s1_valid_q, s1_valid_d, s1_special_q, s1_special_d, s1_sign_q, s1_sign_d;
    logic [W-1:0]         s1_word_q, s1_word_d;
    logic [4:0]           s1_flags_q, s1_flags_d;
    logic signed [XW-1:0] s1_exp_q, s1_exp_d;
    logic [MW-1:0]        s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;

    logic                 s2_valid_q, s2_valid_d, s2_special_q, s2_special_d, s2_sign_q, s2_sign_d;
    logic [W-1:0]         s2_word_q, s2_word_d;
    logic [4:0]           s2_flags_q, s2_flags_d;
    logic signed [XW-1:0] s2_exp_q, s2_exp_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;
    logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;

    logic                 s3_valid_q, s3_valid_d;
    logic [W-1:0]         s3_prod_q, s3_prod_d;
    logic [4:0]           s3_flags_q, s3_flags_d;
    logic [TAG_W-1:0]     s3_tag_q, s3_tag_d;

    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [MAN_W-1:0]     a_man, b_man;
    fp_class_e            cls_a, cls_b;
    logic                 sign_x, special_x;
    logic [W-1:0]         word_x;
    logic [4:0]           flags_x;
    logic [W-1:0]         rnd_word;
    logic [4:0]           rnd_flags;

    assign a_exp  = bus.a[W-2 -: EXP_W];
    assign b_exp  = bus.b[W-2 -: EXP_W];
    assign a_man  = bus.a[MAN_W-1:0];
    assign b_man  = bus.b[MAN_W-1:0];
    assign cls_a  = classify(a_exp, a_man);
    assign cls_b  = classify(b_exp, b_man);
    assign sign_x = bus.a[W-1] ^ bus.b[W-1];

    // S1 resolves every non-numeric outcome up front; S3 just forwards it.
    always_comb begin
        special_x            = 1'b1;
        word_x               = {sign_x, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        flags_x              = '0;
        flags_x[FLAG_DENORM] = (a_exp == '0 && a_man != '0) || (b_exp == '0 && b_man != '0);
        if (cls_a == QNAN || cls_a == SNAN || cls_b == QNAN || cls_b == SNAN) begin
            word_x                = QNAN_W;
            flags_x[FLAG_INVALID] = (cls_a == SNAN) || (cls_b == SNAN);
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            word_x                = QNAN_W;
            flags_x[FLAG_INVALID] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            word_x = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            word_x = {sign_x, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end else begin
            special_x = 1'b0;
        end
    end

    assign adv = !s3_valid_q || bus.out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q; s1_special_d = s1_special_q; s1_sign_d = s1_sign_q;
        s1_word_d  = s1_word_q;  s1_flags_d   = s1_flags_q;   s1_exp_d  = s1_exp_q;
        s1_ma_d    = s1_ma_q;    s1_mb_d      = s1_mb_q;      s1_tag_d  = s1_tag_q;
        s2_valid_d = s2_valid_q; s2_special_d = s2_special_q; s2_sign_d = s2_sign_q;
        s2_word_d  = s2_word_q;  s2_flags_d   = s2_flags_q;   s2_exp_d  = s2_exp_q;
        s2_prod_d  = s2_prod_q;  s2_tag_d     = s2_tag_q;
        s3_valid_d = s3_valid_q; s3_prod_d    = s3_prod_q;    s3_flags_d = s3_flags_q;
        s3_tag_d   = s3_tag_q;
        if (adv) begin
            s1_valid_d   = bus.in_valid;
            s1_special_d = special_x;
            s1_sign_d    = sign_x;
            s1_word_d    = word_x;
            s1_flags_d   = flags_x;
            s1_exp_d     = signed'({2'b00, a_exp}) + signed'({2'b00, b_exp}) - BIAS_S;
            s1_ma_d      = {1'b1, a_man};
            s1_mb_d      = {1'b1, b_man};
            s1_tag_d     = bus.in_tag;

            s2_valid_d   = s1_valid_q;
            s2_special_d = s1_special_q;
            s2_sign_d    = s1_sign_q;
            s2_word_d    = s1_word_q;
            s2_flags_d   = s1_flags_q;
            s2_exp_d     = s1_exp_q;
            s2_prod_d    = PW'(s1_ma_q) * PW'(s1_mb_q);
            s2_tag_d     = s1_tag_q;

            s3_valid_d   = s2_valid_q;
            s3_prod_d    = rnd_word;
            s3_flags_d   = rnd_flags;
            s3_tag_d     = s2_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_special_q <= s1_special_d; s1_sign_q  <= s1_sign_d;  s1_word_q <= s1_word_d;
        s1_flags_q   <= s1_flags_d;   s1_exp_q   <= s1_exp_d;   s1_ma_q   <= s1_ma_d;
        s1_mb_q      <= s1_mb_d;      s1_tag_q   <= s1_tag_d;
        s2_special_q <= s2_special_d; s2_sign_q  <= s2_sign_d;  s2_word_q <= s2_word_d;
        s2_flags_q   <= s2_flags_d;   s2_exp_q   <= s2_exp_d;   s2_prod_q <= s2_prod_d;
        s2_tag_q     <= s2_tag_d;
        s3_prod_q    <= s3_prod_d;    s3_flags_q <= s3_flags_d; s3_tag_q  <= s3_tag_d;
    end

    fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign         (s2_sign_q),
        .exp_in       (s2_exp_q),
        .mprod        (s2_prod_q),
        .special      (s2_special_q),
        .special_word (s2_word_q),
        .flags_in     (s2_flags_q),
        .word         (rnd_word),
        .flags        (rnd_flags)
    );

    assign bus.in_ready  = adv;
    assign bus.out_valid = s3_valid_q;
    assign bus.prod      = s3_prod_q;
    assign bus.out_tag   = s3_tag_q;
    assign bus.flags     = s3_flags_q;

`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
    logic [4:0] sticky_q, sticky_d;

    // A clear in the same cycle as a transfer drops that transfer's flags.
    always_comb begin
        sticky_d = sticky_q;
        if (flags_clr)
            sticky_d = '0;
        else if (s3_valid_q && bus.out_ready)
            sticky_d = sticky_q | s3_flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard bench for fp_mul_pipe (FP_MUL_PIPE_STICKY_FLAGS_EN optional)
module tb_fp_mul_pipe;

    typedef struct {
        logic [31:0] p;
        logic [7:0]  t;
        logic [4:0]  f;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [4:0]  f;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flags_clr;
    logic [4:0] sticky_flags;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    exp_t sb[$];
    logic [4:0] exp_sticky = '0;

    logic        hold_v = 1'b0;
    logic [31:0] hold_p;
    logic [7:0]  hold_t;
    logic [4:0]  hold_f;

    vec_t vecs[14];
    vec_t strm[6];

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) bus ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
        ,
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves in_valid high at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [7:0] t,
                        input logic [31:0] ep, input logic [4:0] ef);
        bit acc;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.in_tag   = t;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) sb.push_back('{ep, t, ef});
            #1;
        end
        if (!acc) check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v     = 1'b0;
            exp_sticky = '0;
        end else begin
            if (hold_v) begin
                check("stall_prod_stable", bus.prod, hold_p);
                check("stall_tag_stable", bus.out_tag, hold_t);
                check("stall_flags_stable", bus.flags, hold_f);
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_p = bus.prod;
            hold_t = bus.out_tag;
            hold_f = bus.flags;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("prod", bus.prod, e.p);
                    check("out_tag", bus.out_tag, e.t);
                    check("flags", bus.flags, e.f);
                    exp_sticky = exp_sticky | e.f;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs = '{
            '{32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000},
            '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010},
            '{32'h7F000000, 32'h40000000, 32'h7F800000, 5'b01010},
            '{32'hFF800000, 32'h00000000, 32'h7FC00000, 5'b10000},
            '{32'h00800000, 32'h3F000000, 32'h00000000, 5'b00110},
            '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00001},
            '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000},
            '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000},
            '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000},
            '{32'h80000000, 32'h40A00000, 32'h80000000, 5'b00000},
            '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00010},
            '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 5'b00010},
            '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 5'b00010},
            '{32'hC0000000, 32'hC0400000, 32'h40C00000, 5'b00000}
        };
        strm = '{
            '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000},
            '{32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000},
            '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000},
            '{32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000},
            '{32'h3F000000, 32'h40800000, 32'h40000000, 5'b00000},
            '{32'h40400000, 32'h40400000, 32'h41100000, 5'b00000}
        };

        rst           = 1'b1;
        flags_clr     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
        check("reset_sticky", {59'd0, sticky_flags}, 64'd0);
`endif
        @(posedge clk);
        #1;

        // Latency: first out_valid must appear after the third edge, counting the accepting one.
        send(32'h3F800000, 32'h3F800000, 8'h01, 32'h3F800000, 5'b00000);
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.out_valid && lat == 0) lat = i;
        end
        check("latency", lat, 3);
        @(posedge clk);
        #1;

        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, 8'h10 + 8'(i), vecs[i].p, vecs[i].f);
        bus.in_valid = 1'b0;
        drain();

`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
        @(negedge clk);
        check("sticky_accum", {59'd0, sticky_flags}, {59'd0, exp_sticky});
        @(posedge clk);
        #1 flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        exp_sticky = '0;
        @(negedge clk);
        check("sticky_clear", {59'd0, sticky_flags}, 64'd0);
        @(posedge clk);
        #1;
`endif

        fork
            begin
                foreach (strm[i]) send(strm[i].a, strm[i].b, 8'hA0 + 8'(i), strm[i].p, strm[i].f);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Three results in flight, none allowed to leave, then reset discards them.
        bus.out_ready = 1'b0;
        send(32'h40000000, 32'h40000000, 8'hC0, 32'h40800000, 5'b00000);
        send(32'h7F000000, 32'h40000000, 8'hC1, 32'h7F800000, 5'b01010);
        send(32'h00000001, 32'h3F800000, 8'hC2, 32'h00000000, 5'b00001);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
            check("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        end
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
        check("post_reset_sticky", {59'd0, sticky_flags}, 64'd0);
`endif
        @(posedge clk);
        #1;

        send(32'h40000000, 32'h40400000, 8'h55, 32'h40C00000, 5'b00000);
        bus.in_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
